// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO sitting directly in front of uart_transmitter. Producers push
// bytes at full clock rate; the FIFO hands them one at a time to the
// transmitter through its data/req/ready handshake and flags (sticky) any
// byte that had to be dropped because the FIFO was full.
//
// Parameters:
//   DEPTH_LOG   log2 of the FIFO depth in bytes (depth = 2**DEPTH_LOG)
//   GAP_CYCLES  idle cycles forced between bytes (optional feature only)
//   GAP_WIDTH   width of the inter-byte gap counter, must hold GAP_CYCLES
//
// Optional feature (compile-time macro):
//   UART_TX_FIFO_GAP_EN  when defined, a GAP_WIDTH-bit down-counter is
//                        loaded with GAP_CYCLES on every pop and tx_req is
//                        held low until it reaches zero. When undefined the
//                        counter does not exist and tx_req = !empty.
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous, active-low reset
//   wr_data[7:0]    byte to enqueue
//   wr_en           enqueue strobe, one byte per cycle while high
//   full            FIFO holds 2**DEPTH_LOG bytes
//   empty           FIFO holds no bytes
//   count           number of bytes stored (DEPTH_LOG+1 bits)
//   overflow        sticky, set when a write is dropped
//   clear_overflow  synchronous clear of overflow (a same-cycle drop wins)
//   tx_data[7:0]    head byte, valid only while tx_req is high
//   tx_req          request to the transmitter
//   tx_ready        ready from the transmitter; req & ready pops a byte
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG  = 4,
  parameter int GAP_CYCLES = 0,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           wr_data,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   count,
  output logic                 overflow,
  input  logic                 clear_overflow,
  output logic [7:0]           tx_data,
  output logic                 tx_req,
  input  logic                 tx_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int PTR_W = DEPTH_LOG + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  // Elaboration-time sanity checks on the parameter set.
  if (DEPTH_LOG < 1) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH_LOG must be at least 1");
  end
  if (GAP_CYCLES < 0 || GAP_WIDTH < 1 ||
      (GAP_WIDTH < 31 && GAP_CYCLES >= (1 << GAP_WIDTH))) begin : g_bad_gap
    $error("uart_tx_fifo: GAP_CYCLES does not fit in GAP_WIDTH bits");
  end

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_accept;
  logic             wr_drop;
  logic             pop;

  // Pointers carry one extra bit so full and empty can be told apart when
  // the index bits match: equal MSBs mean empty, differing MSBs mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

  // Modulo-2**PTR_W subtraction gives the occupancy directly, including
  // across pointer wrap.
  assign count = wr_ptr - rd_ptr;

  // full is taken from the current state, so a write while full is dropped
  // even when a pop frees a slot on the same edge.
  assign wr_accept = wr_en && !full;
  assign wr_drop   = wr_en && full;

  // Same acceptance rule the transmitter uses: req and ready on one edge.
  assign pop = tx_req && tx_ready;

  assign tx_data = mem[rd_ptr[DEPTH_LOG-1:0]];

  // Storage array: written on accepted writes only, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[DEPTH_LOG-1:0]] <= wr_data;
    end
  end

  // Write and read pointers advance independently; a simultaneous write and
  // pop leaves the occupancy unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_TX_FIFO_GAP_EN
  localparam logic [GAP_WIDTH-1:0] GAP_LOAD = GAP_WIDTH'(GAP_CYCLES);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE  = 1;

  logic [GAP_WIDTH-1:0] gap_cnt;

  // Inter-byte gap: reload on every pop, then count down to zero. While it
  // is non-zero the request to the transmitter is suppressed, giving slow
  // receivers idle time between bytes. GAP_CYCLES=0 never blocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (pop) begin
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_ONE;
    end
  end

  assign tx_req = !empty && (gap_cnt == '0);
`else
  assign tx_req = !empty;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed testbench for uart_tx_fifo (DEPTH_LOG=4, depth 16). Inputs are
// driven on the falling clock edge and outputs are checked there as well,
// half a period away from the active rising edge. Expected values are hand
// computed constants or derived from the bench's own byte counters.
// The gap-feature scenario is compiled in only with UART_TX_FIFO_GAP_EN.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_GAP_EN
  localparam int GAP_TB = 3;
`else
  localparam int GAP_TB = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       clear_overflow;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ready;

  int checkCount;
  int passCount;

  uart_tx_fifo #(
    .DEPTH_LOG (4),
    .GAP_CYCLES(GAP_TB),
    .GAP_WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .clear_overflow(clear_overflow),
    .tx_data       (tx_data),
    .tx_req        (tx_req),
    .tx_ready      (tx_ready)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a directed step ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: counts it and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Drive all data/control inputs at once.
  task automatic applyStimulus(input logic we, input logic [7:0] wd,
                               input logic rdy, input logic clr);
    wr_en          = we;
    wr_data        = wd;
    tx_ready       = rdy;
    clear_overflow = clr;
  endtask

  // Advance to the next falling edge (one rising edge in between).
  task automatic cycle();
    @(negedge clk);
  endtask

  // Wait a bounded number of cycles for tx_req, then check it is high.
  task automatic waitReq(input string tag);
    int n;
    n = 0;
    while (!tx_req && n < 20) begin
      cycle();
      n++;
    end
    checkOutput(tag, 32'(tx_req), 32'd1);
  endtask

  initial begin
    int rdN;
    int wrN;
    logic [7:0] b;

    checkCount = 0;
    passCount  = 0;
    reset_n    = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset state.
    #1;
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_req", 32'(tx_req), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();

    // Single byte with ready held: req one cycle after the write, pop next.
    applyStimulus(1'b1, 8'h41, 1'b1, 1'b0);
    cycle();
    checkOutput("t1_req", 32'(tx_req), 32'd1);
    checkOutput("t1_data", 32'(tx_data), 32'h41);
    checkOutput("t1_count", 32'(count), 32'd1);
    checkOutput("t1_empty", 32'(empty), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    cycle();
    checkOutput("t1_empty_after", 32'(empty), 32'd1);
    checkOutput("t1_count_after", 32'(count), 32'd0);
    checkOutput("t1_req_after", 32'(tx_req), 32'd0);

    // Fill to 16 with ready low, then a 17th write is dropped.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      cycle();
      checkOutput("fill_count", 32'(count), 32'(i + 1));
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_ovf_clear", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle();
    checkOutput("drop_ovf", 32'(overflow), 32'd1);
    checkOutput("drop_count", 32'(count), 32'd16);
    checkOutput("drop_full", 32'(full), 32'd1);

    // Clear and drop together: set wins. Then a lone clear.
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1);
    cycle();
    checkOutput("clr_drop_ovf", 32'(overflow), 32'd1);
    checkOutput("clr_drop_count", 32'(count), 32'd16);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    cycle();
    checkOutput("clr_ovf", 32'(overflow), 32'd0);

    // Transmitter-like drain: ready low for 10 cycles after each accept.
    // The first pop coincides with a write while full, which is dropped.
    for (int k = 0; k < 16; k++) begin
      if (k == 0) applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0);
      else        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      checkOutput("drain_req", 32'(tx_req), 32'd1);
      checkOutput("drain_data", 32'(tx_data), 32'(k));
      cycle();
      if (k == 0) begin
        checkOutput("full_pop_count", 32'(count), 32'd15);
        checkOutput("full_pop_ovf", 32'(overflow), 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (10) cycle();
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_req_low", 32'(tx_req), 32'd0);

    // Five queued, then a simultaneous write and pop keeps count at five.
    for (int i = 0; i < 5; i++) begin
      b = 8'h10 + 8'(i);
      applyStimulus(1'b1, b, 1'b0, 1'b0);
      cycle();
    end
    checkOutput("sim_count5", 32'(count), 32'd5);
    checkOutput("sim_head", 32'(tx_data), 32'h10);
    applyStimulus(1'b1, 8'h15, 1'b1, 1'b0);
    cycle();
    checkOutput("sim_count_same", 32'(count), 32'd5);
    checkOutput("sim_new_head", 32'(tx_data), 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int e = 8'h11; e <= 8'h15; e++) begin
      waitReq("sim_wait");
      checkOutput("sim_order", 32'(tx_data), 32'(e));
      cycle();
    end
    cycle();
    checkOutput("sim_empty", 32'(empty), 32'd1);

    // Wrap: 40 bytes through the 16-deep FIFO, ready held high.
    rdN = 0;
    wrN = 0;
    for (int c = 0; c < 400 && rdN < 40; c++) begin
      if (tx_req) begin
        checkOutput("wrap_data", 32'(tx_data), 32'(8'h80 + 8'(rdN)));
        rdN++;
      end
      if (wrN < 40 && !full) begin
        applyStimulus(1'b1, 8'h80 + 8'(wrN), 1'b1, 1'b0);
        wrN++;
      end else begin
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      cycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    checkOutput("wrap_total", 32'(rdN), 32'd40);
    checkOutput("wrap_empty", 32'(empty), 32'd1);

`ifdef UART_TX_FIFO_GAP_EN
    // Gap of three idle cycles between bytes, then reset mid-gap.
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      b = 8'h60 + 8'(i);
      applyStimulus(1'b1, b, 1'b0, 1'b0);
      cycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    checkOutput("gap_req_first", 32'(tx_req), 32'd1);
    checkOutput("gap_data_first", 32'(tx_data), 32'h60);
    cycle();
    for (int g = 0; g < 3; g++) begin
      checkOutput("gap_req_low", 32'(tx_req), 32'd0);
      cycle();
    end
    checkOutput("gap_req_second", 32'(tx_req), 32'd1);
    checkOutput("gap_data_second", 32'(tx_data), 32'h61);
    cycle();
    checkOutput("gap_req_low2", 32'(tx_req), 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("gap_rst_req", 32'(tx_req), 32'd0);
    checkOutput("gap_rst_empty", 32'(empty), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    reset_n = 1'b1;
    cycle();
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
